maple_bus_tx: RTL and testbench

//  Maple Bus line transmitter: host-to-device direction of the FX2 bridge.

---
 rtl/maple_bus_tx.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_maple_bus_tx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maple_bus_tx.sv
// maple_bus_tx: host-to-device Maple Bus line transmitter for the FX2 bridge.
// Each frame has this shape:
//   - a start pattern;
//   - zero or more bytes pulled from the bridge, each sent as MSB-first bit pairs;
//   - an end pattern;
//   - a short idle-high gap, after which the pads are released.
// All outputs are registered.
//
// Optional feature: define MAPLE_TX_CRC_EN to append a running XOR of all sent
// bytes as an extra byte before the end pattern. No tx_read is issued for it.
//
// Parameters
//   CLK_DIV    clk cycles per line slot (>=1)
//   FETCH_LAT  clk cycles from a tx_read pulse to valid tx_data
//   GAP_SLOTS  idle-high slots after the end pattern (>=1)
// Ports
//   clk, reset  system clock; asynchronous active-low reset
//   tx_enable   bridge has data; sampled in IDLE and at each FETCH entry
//   tx_read     one-clk request for the next byte
//   tx_data     byte from the bridge, latched FETCH_LAT clks after tx_read
//   sdcka_out   SDCKA drive value
//   sdckb_out   SDCKB drive value
//   sdck_oe     pad output enable
//   busy        high while a frame is in progress
//   frame_done  one-clk pulse when the gap completes
module maple_bus_tx #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned FETCH_LAT = 3,
  parameter int unsigned GAP_SLOTS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_enable,
  output logic       tx_read,
  input  logic [7:0] tx_data,
  output logic       sdcka_out,
  output logic       sdckb_out,
  output logic       sdck_oe,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned FCH_W   = $clog2(FETCH_LAT + 2);
  localparam int unsigned IDX_MAX = (GAP_SLOTS > 11) ? GAP_SLOTS : 11;
  localparam int unsigned IDX_W   = $clog2(IDX_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FETCH,
    S_SHIFT,
`ifdef MAPLE_TX_CRC_EN
    S_CRC,
`endif
    S_END,
    S_GAP
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [DIV_W-1:0]   r_slot_cnt, w_slot_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [2:0]         r_bit_cnt, w_bit_nxt;
  logic [FCH_W-1:0]   r_fetch_cnt, w_fetch_nxt;
  logic [7:0]         r_shift, w_shift_nxt;
  logic               r_a, w_a_nxt;
  logic               r_b, w_b_nxt;
  logic               r_oe, w_oe_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_rd, w_rd_nxt;
  logic               r_done, w_done_nxt;
`ifdef MAPLE_TX_CRC_EN
  logic [7:0]         r_crc, w_crc_nxt;
  logic               r_crc_sent, w_crc_sent_nxt;
`endif
  logic               w_tick;

  assign w_tick = (r_slot_cnt == DIV_W'(CLK_DIV - 1));

  // Start pattern slot i: 1/1, 0/1, then B toggles 0,1,... with A low, then 1/1.
  function automatic logic [1:0] start_pat(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(0) || i == IDX_W'(10)) return 2'b11;
    else if (i == IDX_W'(1))               return 2'b01;
    else                                   return {1'b0, i[0]};
  endfunction

  // End pattern slot i: 1/0, A toggles 0,1,0,1 with B low, then 1/1.
  function automatic logic [1:0] end_pat(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(0))      return 2'b10;
    else if (i == IDX_W'(5)) return 2'b11;
    else                     return {~i[0], 1'b0};
  endfunction

  // Line values {A,B} for one of the three slots of a data bit.
  // a_clk=1: A is the clock and B carries data; otherwise the roles swap.
  function automatic logic [1:0] bit_pat(input logic a_clk, input logic [1:0] ph,
                                         input logic d);
    if (a_clk) begin
      case (ph)
        2'd0:    return {1'b1, d};
        2'd1:    return {1'b0, d};
        default: return 2'b01;
      endcase
    end else begin
      case (ph)
        2'd0:    return {d, 1'b1};
        2'd1:    return {d, 1'b0};
        default: return 2'b10;
      endcase
    end
  endfunction

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_slot_cnt  <= '0;
      r_idx       <= '0;
      r_bit_cnt   <= '0;
      r_fetch_cnt <= '0;
      r_shift     <= '0;
      r_a         <= 1'b1;
      r_b         <= 1'b1;
      r_oe        <= 1'b0;
      r_busy      <= 1'b0;
      r_rd        <= 1'b0;
      r_done      <= 1'b0;
`ifdef MAPLE_TX_CRC_EN
      r_crc       <= '0;
      r_crc_sent  <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_slot_cnt  <= w_slot_nxt;
      r_idx       <= w_idx_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_fetch_cnt <= w_fetch_nxt;
      r_shift     <= w_shift_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_oe        <= w_oe_nxt;
      r_busy      <= w_busy_nxt;
      r_rd        <= w_rd_nxt;
      r_done      <= w_done_nxt;
`ifdef MAPLE_TX_CRC_EN
      r_crc       <= w_crc_nxt;
      r_crc_sent  <= w_crc_sent_nxt;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = w_tick ? '0 : DIV_W'(r_slot_cnt + 1'b1);
    w_idx_nxt   = r_idx;
    w_bit_nxt   = r_bit_cnt;
    w_fetch_nxt = r_fetch_cnt;
    w_shift_nxt = r_shift;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_oe_nxt    = r_oe;
    w_busy_nxt  = r_busy;
    w_rd_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
`ifdef MAPLE_TX_CRC_EN
    w_crc_nxt      = r_crc;
    w_crc_sent_nxt = r_crc_sent;
`endif

    case (r_state)
      S_IDLE: begin
        w_slot_nxt = '0;
        w_a_nxt    = 1'b1;
        w_b_nxt    = 1'b1;
        w_oe_nxt   = 1'b0;
        w_busy_nxt = 1'b0;
        if (tx_enable) begin
          w_state_nxt = S_START;
          w_idx_nxt   = '0;
          w_oe_nxt    = 1'b1;
          w_busy_nxt  = 1'b1;
`ifdef MAPLE_TX_CRC_EN
          w_crc_nxt      = '0;
          w_crc_sent_nxt = 1'b0;
`endif
        end
      end

      S_START: begin
        if (w_tick) begin
          if (r_idx == IDX_W'(10)) begin
            w_state_nxt = S_FETCH;
            w_fetch_nxt = '0;
          end else begin
            w_idx_nxt          = IDX_W'(r_idx + 1'b1);
            {w_a_nxt, w_b_nxt} = start_pat(IDX_W'(r_idx + 1'b1));
          end
        end
      end

      // tx_enable is only looked at on the first FETCH cycle.
      S_FETCH: begin
        w_slot_nxt = '0;
        if (r_fetch_cnt == '0) begin
          if (!tx_enable) begin
`ifdef MAPLE_TX_CRC_EN
            w_state_nxt = S_CRC;
`else
            w_state_nxt        = S_END;
            w_idx_nxt          = '0;
            {w_a_nxt, w_b_nxt} = end_pat('0);
`endif
          end else begin
            w_rd_nxt    = 1'b1;
            w_fetch_nxt = FCH_W'(1);
          end
        end else if (r_fetch_cnt == FCH_W'(FETCH_LAT + 1)) begin
          w_state_nxt        = S_SHIFT;
          w_fetch_nxt        = '0;
          w_shift_nxt        = tx_data;
          w_bit_nxt          = '0;
          w_idx_nxt          = '0;
          {w_a_nxt, w_b_nxt} = bit_pat(1'b1, 2'd0, tx_data[7]);
`ifdef MAPLE_TX_CRC_EN
          w_crc_nxt          = r_crc ^ tx_data;
`endif
        end else begin
          w_fetch_nxt = FCH_W'(r_fetch_cnt + 1'b1);
        end
      end

`ifdef MAPLE_TX_CRC_EN
      // Check byte goes out through the normal shift path.
      S_CRC: begin
        w_slot_nxt         = '0;
        w_state_nxt        = S_SHIFT;
        w_shift_nxt        = r_crc;
        w_bit_nxt          = '0;
        w_idx_nxt          = '0;
        w_crc_sent_nxt     = 1'b1;
        {w_a_nxt, w_b_nxt} = bit_pat(1'b1, 2'd0, r_crc[7]);
      end
`endif

      // r_idx is the slot within the current bit; even bit counts use A as clock.
      S_SHIFT: begin
        if (w_tick) begin
          if (r_idx != IDX_W'(2)) begin
            w_idx_nxt          = IDX_W'(r_idx + 1'b1);
            {w_a_nxt, w_b_nxt} = bit_pat(~r_bit_cnt[0], 2'(r_idx + 1'b1), r_shift[7]);
          end else if (r_bit_cnt == 3'd7) begin
            w_idx_nxt = '0;
`ifdef MAPLE_TX_CRC_EN
            w_state_nxt = r_crc_sent ? S_END : S_FETCH;
`else
            w_state_nxt = S_FETCH;
`endif
          end else begin
            w_idx_nxt          = '0;
            w_bit_nxt          = 3'(r_bit_cnt + 1'b1);
            w_shift_nxt        = {r_shift[6:0], 1'b0};
            {w_a_nxt, w_b_nxt} = bit_pat(r_bit_cnt[0], 2'd0, r_shift[6]);
          end
        end
      end

      S_END: begin
        if (w_tick) begin
          if (r_idx == IDX_W'(5)) begin
            w_state_nxt = S_GAP;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt          = IDX_W'(r_idx + 1'b1);
            {w_a_nxt, w_b_nxt} = end_pat(IDX_W'(r_idx + 1'b1));
          end
        end
      end

      S_GAP: begin
        if (w_tick) begin
          if (r_idx == IDX_W'(GAP_SLOTS - 1)) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = IDX_W'(r_idx + 1'b1);
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign tx_read    = r_rd;
  assign sdcka_out  = r_a;
  assign sdckb_out  = r_b;
  assign sdck_oe    = r_oe;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_maple_bus_tx.sv
// Bench for maple_bus_tx (CLK_DIV=2, FETCH_LAT=3, GAP_SLOTS=2).
// A frame model builds the expected per-clock trace from the line protocol.
// A compare process checks that trace every cycle.
// A line decoder and literal counts pin the model itself.
module tb_maple_bus_tx;
  localparam int unsigned DIV = 2;
  localparam int unsigned LAT = 3;
  localparam int unsigned GAP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_enable;
  logic       tx_read;
  logic [7:0] tx_data;
  logic       sdcka_out, sdckb_out, sdck_oe, busy, frame_done;

  always #5 clk = ~clk;

  maple_bus_tx #(.CLK_DIV(DIV), .FETCH_LAT(LAT), .GAP_SLOTS(GAP)) dut (
    .clk(clk), .reset(reset), .tx_enable(tx_enable), .tx_read(tx_read),
    .tx_data(tx_data), .sdcka_out(sdcka_out), .sdckb_out(sdckb_out),
    .sdck_oe(sdck_oe), .busy(busy), .frame_done(frame_done)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame model: expected {A,B,oe,rd,busy,done} per clk ----------------
  logic [5:0] exp_q[$];
  logic [7:0] fb[$];
  logic       la, lb;

  task automatic push_cyc(input logic a, input logic b, input logic oe,
                          input logic rd, input logic bz, input logic fd);
    exp_q.push_back({a, b, oe, rd, bz, fd});
    la = a;
    lb = b;
  endtask

  task automatic push_slot(input logic a, input logic b);
    repeat (DIV) push_cyc(a, b, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic push_byte(input logic [7:0] v);
    logic d;
    for (int i = 0; i < 8; i++) begin
      d = v[7-i];
      if (i % 2 == 0) begin
        push_slot(1'b1, d); push_slot(1'b0, d); push_slot(1'b0, 1'b1);
      end else begin
        push_slot(d, 1'b1); push_slot(d, 1'b0); push_slot(1'b1, 1'b0);
      end
    end
  endtask

  task automatic build_frame();
`ifdef MAPLE_TX_CRC_EN
    logic [7:0] crc;
    crc = 8'h00;
`endif
    push_slot(1'b1, 1'b1);
    push_slot(1'b0, 1'b1);
    for (int k = 0; k < 8; k++) push_slot(1'b0, 1'(k % 2));
    push_slot(1'b1, 1'b1);
    foreach (fb[j]) begin
      // Fetch: one decision clk, the read pulse, then LAT clks of bridge latency.
      push_cyc(la, lb, 1'b1, 1'b0, 1'b1, 1'b0);
      push_cyc(la, lb, 1'b1, 1'b1, 1'b1, 1'b0);
      repeat (LAT) push_cyc(la, lb, 1'b1, 1'b0, 1'b1, 1'b0);
      push_byte(fb[j]);
`ifdef MAPLE_TX_CRC_EN
      crc ^= fb[j];
`endif
    end
    push_cyc(la, lb, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef MAPLE_TX_CRC_EN
    push_cyc(la, lb, 1'b1, 1'b0, 1'b1, 1'b0);
    push_byte(crc);
`endif
    push_slot(1'b1, 1'b0); push_slot(1'b0, 1'b0); push_slot(1'b1, 1'b0);
    push_slot(1'b0, 1'b0); push_slot(1'b1, 1'b0); push_slot(1'b1, 1'b1);
    repeat (GAP) push_slot(1'b1, 1'b1);
    push_cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- per-cycle compare ----------------
  bit chk_en = 0;
  bit in_frame = 0;

  always @(negedge clk) begin
    logic [5:0] act;
    logic [5:0] e;
    if (chk_en) begin
      act = {sdcka_out, sdckb_out, sdck_oe, tx_read, busy, frame_done};
      if (!in_frame && exp_q.size() > 0 && sdck_oe) in_frame = 1;
      if (in_frame) begin
        e = exp_q.pop_front();
        check("trace", 32'(act), 32'(e));
        if (exp_q.size() == 0) in_frame = 0;
      end else begin
        check("idle", 32'(act), 32'h30);
      end
    end
  end

  // ---------------- counters ----------------
  int rd_cnt = 0;
  int fd_cnt = 0;
  int oe_cnt = 0;

  always @(negedge clk) begin
    if (tx_read) rd_cnt++;
    if (frame_done) fd_cnt++;
    if (sdck_oe) oe_cnt++;
  end

  // ---------------- line decoder: clock line alternates A, B, A, ... ----------------
  logic       pa = 1'b1, pb = 1'b1;
  bit         dmode = 0;
  bit         exp_a = 1;
  logic [7:0] dsh = 8'h00;
  int         nb = 0;
  logic [7:0] dec_q[$];

  always @(negedge clk) begin
    if (!sdck_oe) begin
      dmode = 0; nb = 0;
    end else if (!dmode) begin
      if (sdcka_out && sdckb_out && !pa) begin dmode = 1; exp_a = 1; nb = 0; end
    end else if (exp_a && pa && !sdcka_out) begin
      dsh = {dsh[6:0], sdckb_out}; nb++; exp_a = 0;
    end else if (!exp_a && pb && !sdckb_out) begin
      dsh = {dsh[6:0], sdcka_out}; nb++; exp_a = 1;
    end
    if (nb == 8) begin dec_q.push_back(dsh); nb = 0; end
    pa = sdcka_out;
    pb = sdckb_out;
  end

  // ---------------- bridge: data valid only on the cycle LAT clks after tx_read ----------------
  logic [7:0] br_q[$];
  logic [7:0] hist = 8'h00;

  always @(negedge clk) begin
    if (!reset) hist = 8'h00;
    else        hist = {hist[6:0], tx_read};
    if (hist[LAT] && br_q.size() > 0) tx_data = br_q.pop_front();
    else                              tx_data = 8'h5A;
  end

  // ---------------- frame driver ----------------
  task automatic run_frame(input int drop_wait);
    int t;
    @(negedge clk);
    rd_cnt = 0; fd_cnt = 0; oe_cnt = 0;
    dec_q.delete();
    foreach (fb[j]) br_q.push_back(fb[j]);
    build_frame();
    tx_enable = 1'b1;
    @(negedge clk);
    check("oe_rise", 32'(sdck_oe), 32'd1);
    if (fb.size() == 0) begin
      tx_enable = 1'b0;
    end else begin
      t = 0;
      while (rd_cnt < fb.size() && t < 2000) begin @(negedge clk); t++; end
      check("read_wait", 32'(t < 2000), 32'd1);
      repeat (drop_wait) @(negedge clk);
      tx_enable = 1'b0;
      repeat (3) @(negedge clk);
      tx_enable = (drop_wait > 0) ? 1'b1 : 1'b0;
      repeat (3) @(negedge clk);
      tx_enable = 1'b0;
    end
    t = 0;
    while ((exp_q.size() > 0 || in_frame) && t < 3000) begin @(negedge clk); t++; end
    check("frame_end_wait", 32'(t < 3000), 32'd1);
    if (t >= 3000) begin exp_q.delete(); in_frame = 0; end
    @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int exp_rd, input int exp_oe,
                             input int exp_n, input logic [31:0] exp_bytes);
    check({tag, "_rd_pulses"}, 32'(rd_cnt), 32'(exp_rd));
    check({tag, "_frame_done"}, 32'(fd_cnt), 32'd1);
    check({tag, "_oe_clks"}, 32'(oe_cnt), 32'(exp_oe));
    check({tag, "_nbytes"}, 32'(dec_q.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < dec_q.size(); i++)
      check({tag, "_byte"}, 32'(dec_q[i]), 32'(exp_bytes[31-8*i -: 8]));
  endtask

  initial begin
    reset = 1'b0;
    tx_enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lines", 32'({sdcka_out, sdckb_out}), 32'h3);
    check("rst_oe_busy", 32'({sdck_oe, busy}), 32'h0);
    check("rst_read_done", 32'({tx_read, frame_done}), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk_en = 1;

    // One byte 0xA5; 86 slot clks plus fetch overhead (5 + 1 final check).
    fb = '{8'hA5};
    run_frame(0);
`ifdef MAPLE_TX_CRC_EN
    check_frame("a5", 1, 141, 2, 32'hA5A5_0000);
`else
    check_frame("a5", 1, 92, 1, 32'hA500_0000);
`endif

    // Reset asserted for one clk in the middle of a byte.
    @(negedge clk);
    chk_en = 0;
    rd_cnt = 0;
    br_q.push_back(8'h3C);
    tx_enable = 1'b1;
    begin
      int t;
      t = 0;
      while (rd_cnt < 1 && t < 200) begin @(negedge clk); t++; end
      check("mid_rst_read_wait", 32'(t < 200), 32'd1);
    end
    repeat (10) @(negedge clk);
    check("mid_rst_pre_oe", 32'(sdck_oe), 32'd1);
    reset = 1'b0;
    tx_enable = 1'b0;
    @(negedge clk);
    check("mid_rst_lines", 32'({sdcka_out, sdckb_out}), 32'h3);
    check("mid_rst_oe_busy", 32'({sdck_oe, busy}), 32'h0);
    check("mid_rst_read", 32'(tx_read), 32'd0);
    reset = 1'b1;
    br_q.delete();
    @(negedge clk);
    chk_en = 1;

    // Three bytes back-to-back.
    fb = '{8'h01, 8'h80, 8'hFF};
    run_frame(0);
`ifdef MAPLE_TX_CRC_EN
    check_frame("three", 3, 247, 4, 32'h0180_FF7E);
`else
    check_frame("three", 3, 198, 3, 32'h0180_FF00);
`endif

    // tx_enable pulsed for a single clk, no data.
    fb.delete();
    run_frame(0);
`ifdef MAPLE_TX_CRC_EN
    check_frame("empty", 0, 88, 1, 32'h0000_0000);
`else
    check_frame("empty", 0, 39, 0, 32'h0000_0000);
`endif

    // Two bytes; with the check byte enabled, the third byte is 0x12^0x34.
    fb = '{8'h12, 8'h34};
    run_frame(0);
`ifdef MAPLE_TX_CRC_EN
    check_frame("pair", 2, 194, 3, 32'h1234_2600);
`else
    check_frame("pair", 2, 145, 2, 32'h1234_0000);
`endif

    // tx_enable drops, briefly returns, and drops again while the byte shifts.
    fb = '{8'hC3};
    run_frame(15);
`ifdef MAPLE_TX_CRC_EN
    check_frame("drop", 1, 141, 2, 32'hC3C3_0000);
`else
    check_frame("drop", 1, 92, 1, 32'hC300_0000);
`endif

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
